pull_responder_fifo: RTL and testbench

Synthesizable data source for the req/ack pull protocol used by the `arf` dataflow graphs: it sits in front of an `in` operator's `din_req_*`/`din_ack_*`/`din_*` port and replaces the behavioural `producer` in hardware builds. A local push-side write port fills an internal FIFO. The pull side answers each `req` with a one-cycle `ack` carrying the next word, following the same rules the operators expect from their upstream.

---
 rtl/arf_pkg.sv | 6 +
 rtl/pull_responder_fifo_pkg.sv | 12 +
 rtl/pull_responder_fifo_if.sv | 20 ++
 rtl/pull_fifo_mem.sv | 22 ++
 rtl/pull_responder_fifo.sv | 84 ++++++++
 tb/tb_pull_responder_fifo.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/arf_pkg.sv
// Constants and types shared across the arf dataflow blocks.
package arf_pkg;
    localparam int ARF_DATA_WIDTH = 32;
    localparam int ARF_FIFO_DEPTH = 8;
    typedef logic [ARF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/pull_responder_fifo_pkg.sv
// Types local to the pull responder: per-cycle FIFO operation decision.
package pull_responder_fifo_pkg;
    import arf_pkg::*;

    localparam int PRF_COUNT_WIDTH = 32;

    typedef struct packed {
        logic push;
        logic drop;
        logic pop;
    } fifo_op_t;
endpackage

// File: rtl/pull_responder_fifo_if.sv
// Push-side write port plus pull-side req/ack port of the responder FIFO.
interface pull_responder_fifo_if #(
    parameter int DW = 32,
    parameter int AW = 3
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [AW:0]   level;
    logic          ovf;
    logic          req;
    logic          ack;
    logic [DW-1:0] dout;
    logic [31:0]   count;

    modport master (output wr_en, wr_data, req,
                    input  full, level, ovf, ack, dout, count);
    modport slave  (input  wr_en, wr_data, req,
                    output full, level, ovf, ack, dout, count);
endinterface

// File: rtl/pull_fifo_mem.sv
// Register array: synchronous write port, asynchronous read port.
module pull_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    // Contents carry no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pull_responder_fifo.sv
// FIFO-backed data source answering req/ack pulls with one-cycle acks.
module pull_responder_fifo
    import pull_responder_fifo_pkg::*;
#(
    parameter  int data_width = arf_pkg::ARF_DATA_WIDTH,
    parameter  int depth      = arf_pkg::ARF_FIFO_DEPTH,
    localparam int addr_width = $clog2(depth)
) (
    input logic                 clk,
    input logic                 rst_n,
    pull_responder_fifo_if.slave bus
);
    localparam logic [addr_width-1:0] PTR_ONE  = addr_width'(1);
    localparam logic [addr_width:0]   LVL_ONE  = (addr_width+1)'(1);
    localparam logic [addr_width:0]   LVL_FULL = (addr_width+1)'(depth);

    logic [addr_width-1:0]      wr_ptr_q, rd_ptr_q;
    logic [addr_width:0]        level_q, level_d;
    logic                       ack_q, ovf_q;
    logic [data_width-1:0]      dout_q, rd_word;
    logic [PRF_COUNT_WIDTH-1:0] count_q;
    logic                       full, empty;
    fifo_op_t                   op;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // Both full and empty come from registered state, so a same-cycle pop
    // never frees room for a push, and a fresh word waits one edge to serve.
    always_comb begin
        op      = '0;
        op.push = bus.wr_en & ~full;
        op.drop = bus.wr_en & full;
        op.pop  = bus.req & ~ack_q & ~empty;
        level_d = level_q;
        case ({op.push, op.pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    pull_fifo_mem #(
        .DW    (data_width),
        .DEPTH (depth),
        .AW    (addr_width)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (op.push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            count_q  <= '0;
        end else begin
            if (op.push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (op.pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                dout_q   <= rd_word;
                count_q  <= count_q + 32'd1;
            end
            if (op.drop) ovf_q <= 1'b1;
            ack_q   <= op.pop;
            level_q <= level_d;
        end
    end

    assign bus.full  = full;
    assign bus.level = level_q;
    assign bus.ovf   = ovf_q;
    assign bus.ack   = ack_q;
    assign bus.dout  = dout_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_pull_responder_fifo.sv
// Bench for pull_responder_fifo: vector table, corner sequences, random vs queue model.
module tb_pull_responder_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pull_responder_fifo_if #(.DW(DW), .AW(AW)) bus ();

    pull_responder_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] d, input logic rq);
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.req     = rq;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rq;
        logic        ack;
        logic [31:0] dout;
        int          lvl;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [12];

    // Reference model: a plain queue of stored words.
    logic [31:0] q_m [$];
    logic        ack_m, ovf_m;
    logic [31:0] dout_m, cnt_m;

    task automatic model_reset();
        q_m.delete();
        ack_m  = 1'b0;
        ovf_m  = 1'b0;
        dout_m = '0;
        cnt_m  = '0;
    endtask

    task automatic model_edge(input logic wr, input logic [31:0] d, input logic rq);
        bit was_full;
        bit pop;
        was_full = (q_m.size() == DEPTH);
        pop      = rq && !ack_m && (q_m.size() != 0);
        if (pop) begin
            dout_m = q_m.pop_front();
            cnt_m  = cnt_m + 1;
        end
        ack_m = pop;
        if (wr) begin
            if (was_full) ovf_m = 1'b1;
            else          q_m.push_back(d);
        end
    endtask

    task automatic model_check(input logic prev_ack);
        chk("m_ack",   {31'd0, bus.ack},   {31'd0, ack_m});
        chk("m_dout",  bus.dout,           dout_m);
        chk("m_level", 32'(bus.level),     32'(q_m.size()));
        chk("m_full",  {31'd0, bus.full},  {31'd0, q_m.size() == DEPTH});
        chk("m_ovf",   {31'd0, bus.ovf},   {31'd0, ovf_m});
        chk("m_count", bus.count,          cnt_m);
        chk("ack_b2b", {31'd0, prev_ack & bus.ack}, 32'd0);
    endtask

    task automatic run_random(input int cycles, input int wr_pct, input int rq_pct);
        logic wr, rq, prev;
        logic [31:0] d;
        prev = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            wr = ($urandom_range(99) < wr_pct);
            rq = ($urandom_range(99) < rq_pct);
            d  = $urandom;
            drive(wr, d, rq);
            model_edge(wr, d, rq);
            step();
            model_check(prev);
            prev = bus.ack;
        end
    endtask

    initial begin
        logic [31:0] exp_add [5];

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        #12;
        chk("rst_ack",   {31'd0, bus.ack},  32'd0);
        chk("rst_dout",  bus.dout,          32'd0);
        chk("rst_count", bus.count,         32'd0);
        chk("rst_level", 32'(bus.level),    32'd0);
        chk("rst_full",  {31'd0, bus.full}, 32'd0);
        chk("rst_ovf",   {31'd0, bus.ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Push 10,11,12, pull them on alternate cycles, then push into empty with req held.
        tbl[0]  = '{1'b1, 32'd10, 1'b0, 1'b0, 32'd0,  1, 32'd0};
        tbl[1]  = '{1'b1, 32'd11, 1'b0, 1'b0, 32'd0,  2, 32'd0};
        tbl[2]  = '{1'b1, 32'd12, 1'b0, 1'b0, 32'd0,  3, 32'd0};
        tbl[3]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd10, 2, 32'd1};
        tbl[4]  = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd10, 2, 32'd1};
        tbl[5]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd11, 1, 32'd2};
        tbl[6]  = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd11, 1, 32'd2};
        tbl[7]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd12, 0, 32'd3};
        tbl[8]  = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd12, 0, 32'd3};
        tbl[9]  = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd12, 0, 32'd3};
        tbl[10] = '{1'b1, 32'd20, 1'b1, 1'b0, 32'd12, 1, 32'd3};
        tbl[11] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd20, 0, 32'd4};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wr, tbl[i].d, tbl[i].rq);
            step();
            chk("tbl_ack",   {31'd0, bus.ack}, {31'd0, tbl[i].ack});
            chk("tbl_dout",  bus.dout,         tbl[i].dout);
            chk("tbl_level", 32'(bus.level),   32'(tbl[i].lvl));
            chk("tbl_count", bus.count,        tbl[i].cnt);
        end

        // Overfill: 9 pushes into depth 8, ninth word is dropped.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            step();
            if (i == 7) begin
                chk("full_after8", {31'd0, bus.full}, 32'd1);
                chk("ovf_after8",  {31'd0, bus.ovf},  32'd0);
            end
        end
        chk("ovf_after9",   {31'd0, bus.ovf}, 32'd1);
        chk("level_after9", 32'(bus.level),   32'd8);
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("drain_ack",  {31'd0, bus.ack}, 32'd1);
            chk("drain_dout", bus.dout,         32'(k));
            step();
            chk("drain_gap",  {31'd0, bus.ack}, 32'd0);
        end
        chk("drain_level", 32'(bus.level),   32'd0);
        chk("drain_full",  {31'd0, bus.full}, 32'd0);
        chk("drain_count", bus.count,        32'd12);

        // Feed an addi(2) consumer with 0..4.
        exp_add = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("addi_ack", {31'd0, bus.ack}, 32'd1);
            chk("addi_out", bus.dout + 32'd2, exp_add[k]);
            step();
        end

        // Async reset with 5 words stored and ack high.
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(100 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1);
        step();
        chk("pre_rst_ack",   {31'd0, bus.ack}, 32'd1);
        chk("pre_rst_level", 32'(bus.level),   32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_ack",   {31'd0, bus.ack},  32'd0);
        chk("arst_dout",  bus.dout,          32'd0);
        chk("arst_count", bus.count,         32'd0);
        chk("arst_level", 32'(bus.level),    32'd0);
        chk("arst_ovf",   {31'd0, bus.ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ack",   {31'd0, bus.ack}, 32'd0);
            chk("post_rst_level", 32'(bus.level),   32'd0);
        end

        // Random traffic, then saturating push+req to wrap pointers and overflow.
        model_reset();
        run_random(400, 50, 60);
        run_random(120, 100, 100);
        run_random(200, 30, 90);

        drive(1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
